// File: rtl/icache_responder_pkg.sv
// Shared types and defaults for the instruction cache.
//   V32            : 32-bit word
//   t_icache_state : lookup/refill state (IDLE, FILL, DONE)
//   ICACHE_LINES / ICACHE_WORDS : default geometry
package icache_responder_pkg;
  typedef logic [31:0] V32;
  typedef enum logic [1:0] {IDLE, FILL, DONE} t_icache_state;
  localparam int ICACHE_LINES = 16;
  localparam int ICACHE_WORDS = 4;
endpackage

// File: rtl/icache_responder_line_store.sv
// Valid/tag/data arrays of the direct-mapped instruction cache.
//   clock, reset           : posedge clock, sync active-high reset (clears valid only)
//   rd_index/rd_offset     : combinational read -> rd_valid, rd_tag, rd_data
//   wr_en/wr_index/wr_offset/wr_data : one-word write
//   tag_en/tag_index/tag_value       : tag write + set valid
//   clr_en/clr_index       : clear one valid bit
module icache_responder_line_store
  import icache_responder_pkg::*;
#(
  parameter int LINES = ICACHE_LINES,
  parameter int WORDS = ICACHE_WORDS,
  parameter int IW    = $clog2(LINES),
  parameter int OW    = $clog2(WORDS),
  parameter int TW    = 30 - IW - OW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [IW-1:0] rd_index,
  input  logic [OW-1:0] rd_offset,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output V32            rd_data,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_index,
  input  logic [OW-1:0] wr_offset,
  input  V32            wr_data,
  input  logic          tag_en,
  input  logic [IW-1:0] tag_index,
  input  logic [TW-1:0] tag_value,
  input  logic          clr_en,
  input  logic [IW-1:0] clr_index
);
  logic [LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]    tag_q  [LINES];
  logic [TW-1:0]    tag_d  [LINES];
  V32               data_q [LINES][WORDS];
  V32               data_d [LINES][WORDS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_offset];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) data_d[wr_index][wr_offset] = wr_data;
    if (tag_en) begin
      tag_d[tag_index]   = tag_value;
      valid_d[tag_index] = 1'b1;
    end
    if (clr_en) valid_d[clr_index] = 1'b0;
    if (reset)  valid_d = '0;
  end

  // Tags and data are left unreset; valid bits alone gate hits.
  always_ff @(posedge clock) begin
    valid_q <= valid_d;
    tag_q   <= tag_d;
    data_q  <= data_d;
  end
endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache with same-cycle hits and line refill.
//   clock, reset        : posedge clock, sync active-high reset
//   fetch_enable        : lookup qualifier
//   fetch_address       : byte address ([1:0] ignored)
//   fetch_instruction   : word on hit, else 0 (combinational)
//   fetch_stall         : instruction not available
//   mem_request/mem_address : registered refill request and line base
//   mem_valid/mem_data  : refill beats, ascending word order
//   hit_count/miss_count: registered wrapping counters
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int LINES = ICACHE_LINES,
  parameter int WORDS = ICACHE_WORDS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_enable,
  input  logic [31:0] fetch_address,
  output logic [31:0] fetch_instruction,
  output logic        fetch_stall,
  output logic        mem_request,
  output logic [31:0] mem_address,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(LINES);
  localparam int LO = OW + 2;          // lowest index bit
  localparam int TW = 30 - OW - IW;

  t_icache_state state_q, state_d;
  logic          mem_request_q, mem_request_d;
  V32            mem_address_q, mem_address_d;
  logic [OW-1:0] beat_q, beat_d;
  V32            hit_count_q, hit_count_d;
  V32            miss_count_q, miss_count_d;

  logic [OW-1:0] req_offset;
  logic [IW-1:0] req_index, fill_index;
  logic [TW-1:0] req_tag, fill_tag, rd_tag;
  logic          rd_valid, hit;
  V32            rd_data;
  logic          wr_en, tag_en, clr_en;
  logic          unused_byte_bits;

  assign req_offset       = fetch_address[LO-1:2];
  assign req_index        = fetch_address[LO+IW-1:LO];
  assign req_tag          = fetch_address[31:LO+IW];
  assign unused_byte_bits = ^fetch_address[1:0];
  // The fill target comes from the latched line base, so the fetch
  // address may wander during a fill.
  assign fill_index       = mem_address_q[LO+IW-1:LO];
  assign fill_tag         = mem_address_q[31:LO+IW];

  icache_responder_line_store #(.LINES(LINES), .WORDS(WORDS)) u_store (
    .clock     (clock),
    .reset     (reset),
    .rd_index  (req_index),
    .rd_offset (req_offset),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_index  (fill_index),
    .wr_offset (beat_q),
    .wr_data   (mem_data),
    .tag_en    (tag_en),
    .tag_index (fill_index),
    .tag_value (fill_tag),
    .clr_en    (clr_en),
    .clr_index (req_index)
  );

  assign hit               = rd_valid && (rd_tag == req_tag) && (state_q == IDLE);
  assign fetch_instruction = hit ? rd_data : '0;
  assign fetch_stall       = (state_q != IDLE) || (fetch_enable && !hit);
  assign mem_request       = mem_request_q;
  assign mem_address       = mem_address_q;
  assign hit_count         = hit_count_q;
  assign miss_count        = miss_count_q;

  always_comb begin
    state_d       = state_q;
    mem_request_d = mem_request_q;
    mem_address_d = mem_address_q;
    beat_d        = beat_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    wr_en         = 1'b0;
    tag_en        = 1'b0;
    clr_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_enable) begin
          if (hit) begin
            hit_count_d = hit_count_q + 32'd1;
          end else begin
            mem_address_d = {fetch_address[31:LO], LO'(0)};
            mem_request_d = 1'b1;
            miss_count_d  = miss_count_q + 32'd1;
            beat_d        = '0;
            clr_en        = 1'b1;
            state_d       = FILL;
          end
        end
      end
      FILL: begin
        if (mem_valid) begin
          wr_en  = 1'b1;
          beat_d = beat_q + OW'(1);
          if (beat_q == OW'(WORDS - 1)) begin
            mem_request_d = 1'b0;
            tag_en        = 1'b1;
            beat_d        = '0;
            state_d       = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reset) begin
      state_d       = IDLE;
      mem_request_d = 1'b0;
      mem_address_d = '0;
      beat_d        = '0;
      hit_count_d   = '0;
      miss_count_d  = '0;
      wr_en         = 1'b0;
      tag_en        = 1'b0;
      clr_en        = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    state_q       <= state_d;
    mem_request_q <= mem_request_d;
    mem_address_q <= mem_address_d;
    beat_q        <= beat_d;
    hit_count_q   <= hit_count_d;
    miss_count_q  <= miss_count_d;
  end
endmodule

// File: tb/tb_icache_responder.sv
module tb_icache_responder;
  logic        clock = 1'b0;
  logic        reset, fetch_enable, mem_valid;
  logic [31:0] fetch_address, mem_data;
  logic [31:0] fetch_instruction, mem_address, hit_count, miss_count;
  logic        fetch_stall, mem_request;

  int checks = 0;
  int errors = 0;

  icache_responder #(.LINES(16), .WORDS(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .fetch_enable      (fetch_enable),
    .fetch_address     (fetch_address),
    .fetch_instruction (fetch_instruction),
    .fetch_stall       (fetch_stall),
    .mem_request       (mem_request),
    .mem_address       (mem_address),
    .mem_valid         (mem_valid),
    .mem_data          (mem_data),
    .hit_count         (hit_count),
    .miss_count        (miss_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          rst, chk;
    logic        en;
    logic [31:0] addr;
    logic        mv;
    logic [31:0] md;
    logic        stall;
    logic [31:0] instr;
    logic        req;
    logic [31:0] maddr, hits, misses;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, bit chk, logic en, logic [31:0] addr,
                              logic mv, logic [31:0] md, logic stall,
                              logic [31:0] instr, logic req, logic [31:0] maddr,
                              logic [31:0] hits, logic [31:0] misses);
    vec_t v;
    v.rst = rst; v.chk = chk; v.en = en; v.addr = addr; v.mv = mv; v.md = md;
    v.stall = stall; v.instr = instr; v.req = req; v.maddr = maddr;
    v.hits = hits; v.misses = misses;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    int cyc;
    reset = 1'b1; fetch_enable = 1'b0; fetch_address = '0;
    mem_valid = 1'b0; mem_data = '0;

    //  rst chk en addr      mv md     stall instr req maddr    hits misses
    add(1, 0, 0, 32'h0,     0, 0,     0, 0,     0, 32'h0,   0, 0);
    add(1, 0, 0, 32'h0,     0, 0,     0, 0,     0, 32'h0,   0, 0);
    // cold miss on 0x40, back-to-back beats
    add(0, 1, 1, 32'h40,    0, 0,     1, 0,     0, 32'h0,   0, 0);
    add(0, 1, 1, 32'h40,    1, 'hA0,  1, 0,     1, 32'h40,  0, 1);
    add(0, 1, 1, 32'h40,    1, 'hA1,  1, 0,     1, 32'h40,  0, 1);
    add(0, 1, 1, 32'h40,    1, 'hA2,  1, 0,     1, 32'h40,  0, 1);
    add(0, 1, 1, 32'h40,    1, 'hA3,  1, 0,     1, 32'h40,  0, 1);
    add(0, 1, 1, 32'h40,    0, 0,     1, 0,     0, 32'h40,  0, 1);
    // sequential hits
    add(0, 1, 1, 32'h40,    0, 0,     0, 'hA0,  0, 32'h40,  0, 1);
    add(0, 1, 1, 32'h44,    0, 0,     0, 'hA1,  0, 32'h40,  1, 1);
    add(0, 1, 1, 32'h48,    0, 0,     0, 'hA2,  0, 32'h40,  2, 1);
    add(0, 1, 1, 32'h4C,    0, 0,     0, 'hA3,  0, 32'h40,  3, 1);
    // disabled lookup still returns cached word, counts nothing
    add(0, 1, 0, 32'h40,    0, 0,     0, 'hA0,  0, 32'h40,  4, 1);
    // conflict: 0x140 maps to index 4 with tag 1
    add(0, 1, 1, 32'h140,   0, 0,     1, 0,     0, 32'h40,  4, 1);
    add(0, 1, 1, 32'h140,   1, 'hB0,  1, 0,     1, 32'h140, 4, 2);
    add(0, 1, 1, 32'h140,   1, 'hB1,  1, 0,     1, 32'h140, 4, 2);
    add(0, 1, 1, 32'h140,   1, 'hB2,  1, 0,     1, 32'h140, 4, 2);
    add(0, 1, 1, 32'h140,   1, 'hB3,  1, 0,     1, 32'h140, 4, 2);
    add(0, 1, 1, 32'h140,   0, 0,     1, 0,     0, 32'h140, 4, 2);
    add(0, 1, 1, 32'h14C,   0, 0,     0, 'hB3,  0, 32'h140, 4, 2);
    // 0x40 misses again; gapped beats, address wanders mid-fill
    add(0, 1, 1, 32'h40,    0, 0,     1, 0,     0, 32'h140, 5, 2);
    add(0, 1, 1, 32'h40,    0, 0,     1, 0,     1, 32'h40,  5, 3);
    add(0, 1, 1, 32'h40,    1, 'hC0,  1, 0,     1, 32'h40,  5, 3);
    add(0, 1, 1, 32'h240,   0, 0,     1, 0,     1, 32'h40,  5, 3);
    add(0, 1, 1, 32'h240,   1, 'hC1,  1, 0,     1, 32'h40,  5, 3);
    add(0, 1, 0, 32'h0,     0, 0,     1, 0,     1, 32'h40,  5, 3);
    add(0, 1, 1, 32'h40,    1, 'hC2,  1, 0,     1, 32'h40,  5, 3);
    add(0, 1, 1, 32'h40,    0, 0,     1, 0,     1, 32'h40,  5, 3);
    add(0, 1, 1, 32'h40,    1, 'hC3,  1, 0,     1, 32'h40,  5, 3);
    add(0, 1, 1, 32'h40,    0, 0,     1, 0,     0, 32'h40,  5, 3);
    add(0, 1, 1, 32'h40,    1, 'hDEAD,0, 'hC0,  0, 32'h40,  5, 3);
    add(0, 1, 1, 32'h44,    0, 0,     0, 'hC1,  0, 32'h40,  6, 3);
    add(0, 1, 1, 32'h48,    0, 0,     0, 'hC2,  0, 32'h40,  7, 3);
    add(0, 1, 1, 32'h4C,    1, 'hBEEF,0, 'hC3,  0, 32'h40,  8, 3);
    add(0, 1, 1, 32'h40,    0, 0,     0, 'hC0,  0, 32'h40,  9, 3);
    // 0x140 was evicted
    add(0, 1, 1, 32'h140,   0, 0,     1, 0,     0, 32'h40, 10, 3);
    add(0, 1, 1, 32'h140,   1, 'hD0,  1, 0,     1, 32'h140,10, 4);
    add(0, 1, 1, 32'h140,   1, 'hD1,  1, 0,     1, 32'h140,10, 4);
    // reset mid-fill
    add(1, 0, 1, 32'h140,   0, 0,     0, 0,     0, 32'h0,   0, 0);
    add(0, 1, 0, 32'h140,   1, 'hD2,  0, 0,     0, 32'h0,   0, 0);
    add(0, 1, 0, 32'h1000,  1, 'hD3,  0, 0,     0, 32'h0,   0, 0);
    add(0, 1, 1, 32'h40,    0, 0,     1, 0,     0, 32'h0,   0, 0);
    add(0, 1, 1, 32'h40,    0, 0,     1, 0,     1, 32'h40,  0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; fetch_enable = vecs[i].en; fetch_address = vecs[i].addr;
      mem_valid = vecs[i].mv; mem_data = vecs[i].md;
      #2;
      if (vecs[i].chk) begin
        chk("fetch_stall", i, {31'd0, fetch_stall}, {31'd0, vecs[i].stall});
        chk("fetch_instruction", i, fetch_instruction, vecs[i].instr);
        chk("mem_request", i, {31'd0, mem_request}, {31'd0, vecs[i].req});
        chk("mem_address", i, mem_address, vecs[i].maddr);
        chk("hit_count", i, hit_count, vecs[i].hits);
        chk("miss_count", i, miss_count, vecs[i].misses);
      end
      @(posedge clock); #1;
    end

    // Finish the post-reset refill of 0x40 by hand, then wait (bounded)
    // for the stall to drop and read a word from the new line.
    for (int b = 0; b < 4; b++) begin
      mem_valid = 1'b1; mem_data = 32'hE0 + b;
      @(posedge clock); #1;
    end
    mem_valid = 1'b0; fetch_address = 32'h48;
    cyc = 0;
    #2;
    while (fetch_stall && cyc < 20) begin
      @(posedge clock); #3;
      cyc++;
    end
    chk("stall_release_cycles", 100, cyc, 1);
    chk("refill_word2", 100, fetch_instruction, 32'hE2);
    chk("refill_miss_count", 100, miss_count, 32'd1);
    chk("refill_hit_count_before", 100, hit_count, 32'd0);
    @(posedge clock); #1;
    fetch_address = 32'h4C;
    #2;
    chk("refill_word3", 101, fetch_instruction, 32'hE3);
    chk("refill_hit_count_after", 101, hit_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
